// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo: scans a ROWS x COLS switch matrix one column at a time, debounces every key
// independently and queues press events (and optionally release events) in a first-word-fall-
// through FIFO.
//
// Ports:
//   clk          sole clock
//   RST_BTN      synchronous active-high reset
//   col_drive    active-low column strobe; exactly one bit is low, registered
//   row_sense    active-low row returns (pulled up externally); sampled on the last dwell cycle
//   key_valid    FIFO head holds an event
//   key_code     head event code = row*COLS + col (0 when empty)
//   key_release  head event is a release (0 when empty; constant 0 without the macro)
//   key_ready    consumer pops the head when key_valid & key_ready
//   any_held     at least one debounced key is down, registered
//   overflow     sticky: an event was dropped because the FIFO was full
//
// Build option: define KEYPAD_RELEASE_EVENTS_EN to queue release events as well as presses.
//
// row_sense is used directly at the sample point. The dwell is long compared with the settling
// of the matrix, but a truly asynchronous source should be synchronized upstream.
module keypad_scan_fifo #(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned FIFO_DEPTH     = 8,
  localparam int unsigned KW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic            clk,
  input  logic            RST_BTN,
  output logic [COLS-1:0] col_drive,
  input  logic [ROWS-1:0] row_sense,
  output logic            key_valid,
  output logic [KW-1:0]   key_code,
  output logic            key_release,
  input  logic            key_ready,
  output logic            any_held,
  output logic            overflow
);

  localparam int unsigned NKEYS = ROWS * COLS;
  localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned DW    = $clog2(SCAN_DIV);
  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  DB    = 4'(DEBOUNCE_SCANS);
`ifdef KEYPAD_RELEASE_EVENTS_EN
  localparam int unsigned EW    = KW + 1;  // {release, code}
`else
  localparam int unsigned EW    = KW;
`endif

  // Scan timing
  logic [CW-1:0]   col_q, col_d;
  logic [DW-1:0]   div_q, div_d;
  logic [COLS-1:0] col_drive_q, col_drive_d;
  logic            sample;

  assign sample = (div_q == DW'(SCAN_DIV - 1));

  always_comb begin
    div_d = div_q + 1'b1;
    col_d = col_q;
    if (sample) begin
      div_d = '0;
      col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
    end
    // Driven from the next index so col_drive always lines up with col_q.
    col_drive_d = '1;
    for (int c = 0; c < COLS; c++) begin
      if (col_d == CW'(c)) col_drive_d[c] = 1'b0;
    end
  end

  // Debounce and event generation
  logic [NKEYS-1:0]      state_q, state_d;
  logic [NKEYS-1:0][3:0] cnt_q, cnt_d;
  logic                  push_q, push_d;
  logic [KW-1:0]         push_code_q, push_code_d;
  logic                  any_held_q;
`ifdef KEYPAD_RELEASE_EVENTS_EN
  logic                  push_rel_q, push_rel_d;
`endif

  always_comb begin
    logic       pressed;
    logic [3:0] cnt_inc;
    logic       won;
    pressed     = 1'b0;
    cnt_inc     = '0;
    won         = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    push_d      = 1'b0;
    push_code_d = '0;
`ifdef KEYPAD_RELEASE_EVENTS_EN
    push_rel_d  = 1'b0;
`endif
    if (sample) begin
      // Rows are visited in ascending order so the lowest qualifying row wins the commit.
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (col_q == CW'(c)) begin
            pressed = ~row_sense[r];
            if (pressed == state_q[r*COLS+c]) begin
              cnt_d[r*COLS+c] = '0;
            end else begin
              cnt_inc = (cnt_q[r*COLS+c] >= DB) ? cnt_q[r*COLS+c] : cnt_q[r*COLS+c] + 4'd1;
              if (cnt_inc == DB && !won) begin
                won               = 1'b1;
                state_d[r*COLS+c] = pressed;
                cnt_d[r*COLS+c]   = '0;
                push_code_d       = KW'(r * COLS + c);
`ifdef KEYPAD_RELEASE_EVENTS_EN
                push_d            = 1'b1;
                push_rel_d        = ~pressed;
`else
                push_d            = pressed;
`endif
              end else begin
                // Losers stay saturated and retry on the next visit to this column.
                cnt_d[r*COLS+c] = cnt_inc;
              end
            end
          end
        end
      end
    end
  end

  // Event FIFO
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   count_q;
  logic          overflow_q;
  logic          full, pop, do_write, drop;
  logic [EW-1:0] wr_entry, head;

  assign full     = (count_q == (PW + 1)'(FIFO_DEPTH));
  assign key_valid = (count_q != '0);
  assign pop      = key_valid & key_ready;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign do_write = push_q & (~full | pop);
  assign drop     = push_q & full & ~pop;
  assign head     = mem[rd_q];

`ifdef KEYPAD_RELEASE_EVENTS_EN
  assign wr_entry    = {push_rel_q, push_code_q};
  assign key_release = key_valid & head[KW];
`else
  assign wr_entry    = push_code_q;
  assign key_release = 1'b0;
`endif
  assign key_code  = key_valid ? head[KW-1:0] : '0;
  assign col_drive = col_drive_q;
  assign any_held  = any_held_q;
  assign overflow  = overflow_q;

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_q] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (RST_BTN) begin
      col_q       <= '0;
      div_q       <= '0;
      col_drive_q <= ~COLS'(1);
      state_q     <= '0;
      cnt_q       <= '0;
      any_held_q  <= 1'b0;
      push_q      <= 1'b0;
      push_code_q <= '0;
`ifdef KEYPAD_RELEASE_EVENTS_EN
      push_rel_q  <= 1'b0;
`endif
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      div_q       <= div_d;
      col_drive_q <= col_drive_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      any_held_q  <= |state_d;
      push_q      <= push_d;
      push_code_q <= push_code_d;
`ifdef KEYPAD_RELEASE_EVENTS_EN
      push_rel_q  <= push_rel_d;
`endif
      if (do_write) wr_q <= wr_q + 1'b1;
      if (pop)      rd_q <= rd_q + 1'b1;
      case ({do_write, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_SCANS=2,
// FIFO_DEPTH=4). A behavioural switch matrix pulls a row low while its key is down and its
// column is strobed. "cyc" counts cycles since the last reset edge: cycle k is dwell cycle k%4
// of column (k/4)%4, so samples happen at k%4 == 3 and a column c is sampled at 16n+4c+3.
module tb_keypad_scan_fifo;

  logic        clk = 1'b0;
  logic        RST_BTN = 1'b1;
  logic        key_ready = 1'b0;
  logic [3:0]  col_drive;
  logic [3:0]  row_sense;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_release;
  logic        any_held;
  logic        overflow;
  logic [15:0] keys_down = '0;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  keypad_scan_fifo #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(2), .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .RST_BTN    (RST_BTN),
    .col_drive  (col_drive),
    .row_sense  (row_sense),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_release(key_release),
    .key_ready  (key_ready),
    .any_held   (any_held),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= RST_BTN ? 0 : cyc + 1;

  always_comb begin
    row_sense = '1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys_down[r*4+c] && col_drive[c] === 1'b0) row_sense[r] = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    for (int i = 0; i < 400 && cyc != t; i++) tick();
    if (cyc != t) begin
      vectors++; miscompares++;
      $display("FAIL wait_cyc: reached cycle %0d, wanted %0d", cyc, t);
    end
  endtask

  task automatic do_reset();
    RST_BTN = 1'b1;
    tick();
    tick();
    RST_BTN = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_cd;
    do_reset();
    vectors++; if (col_drive !== 4'b1110) begin miscompares++;
      $display("FAIL rst_col_drive: got %b expected %b", col_drive, 4'b1110); end
    vectors++; if (key_valid !== 1'b0) begin miscompares++;
      $display("FAIL rst_key_valid: got %b expected 0", key_valid); end
    vectors++; if (key_code !== 4'd0) begin miscompares++;
      $display("FAIL rst_key_code: got %0d expected 0", key_code); end
    vectors++; if (key_release !== 1'b0) begin miscompares++;
      $display("FAIL rst_key_release: got %b expected 0", key_release); end
    vectors++; if (any_held !== 1'b0) begin miscompares++;
      $display("FAIL rst_any_held: got %b expected 0", any_held); end
    vectors++; if (overflow !== 1'b0) begin miscompares++;
      $display("FAIL rst_overflow: got %b expected 0", overflow); end
    for (int k = 0; k < 20; k++) begin
      exp_cd = ~(4'b0001 << ((cyc / 4) % 4));
      vectors++; if (col_drive !== exp_cd) begin miscompares++;
        $display("FAIL scan_col_drive cyc %0d: got %b expected %b", cyc, col_drive, exp_cd); end
      tick();
    end
  endtask

  // Key 6 = row 1, column 2; column 2 is sampled at 11, 27, 43, 59, 75.
  task automatic test_press_release();
    do_reset();
    keys_down[6] = 1'b1;
    wait_cyc(28);
    vectors++; if (key_valid !== 1'b0) begin miscompares++;
      $display("FAIL press_early_valid: got %b expected 0", key_valid); end
    vectors++; if (any_held !== 1'b1) begin miscompares++;
      $display("FAIL press_any_held: got %b expected 1", any_held); end
    wait_cyc(29);
    vectors++; if (key_valid !== 1'b1) begin miscompares++;
      $display("FAIL press_valid: got %b expected 1", key_valid); end
    vectors++; if (key_code !== 4'd6) begin miscompares++;
      $display("FAIL press_code: got %0d expected 6", key_code); end
    vectors++; if (key_release !== 1'b0) begin miscompares++;
      $display("FAIL press_release_flag: got %b expected 0", key_release); end
    wait_cyc(44);
    keys_down[6] = 1'b0;
    wait_cyc(74);
    vectors++; if (any_held !== 1'b1) begin miscompares++;
      $display("FAIL release_early_held: got %b expected 1", any_held); end
    wait_cyc(76);
    vectors++; if (any_held !== 1'b0) begin miscompares++;
      $display("FAIL release_any_held: got %b expected 0", any_held); end
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
`ifdef KEYPAD_RELEASE_EVENTS_EN
    vectors++; if (key_valid !== 1'b1 || key_code !== 4'd6 || key_release !== 1'b1) begin
      miscompares++;
      $display("FAIL release_event: got v=%b code=%0d rel=%b expected v=1 code=6 rel=1",
               key_valid, key_code, key_release); end
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
`endif
    vectors++; if (key_valid !== 1'b0 || key_code !== 4'd0) begin miscompares++;
      $display("FAIL release_drained: got v=%b code=%0d expected v=0 code=0",
               key_valid, key_code); end
  endtask

  // One-sample glitch on key 0 must reset its counter; a later real press needs two samples.
  task automatic test_glitch();
    do_reset();
    keys_down[0] = 1'b1;
    wait_cyc(4);
    keys_down[0] = 1'b0;
    wait_cyc(20);
    keys_down[0] = 1'b1;
    wait_cyc(40);
    vectors++; if (key_valid !== 1'b0) begin miscompares++;
      $display("FAIL glitch_no_event: got %b expected 0", key_valid); end
    vectors++; if (any_held !== 1'b0) begin miscompares++;
      $display("FAIL glitch_any_held: got %b expected 0", any_held); end
    wait_cyc(53);
    vectors++; if (key_valid !== 1'b1 || key_code !== 4'd0) begin miscompares++;
      $display("FAIL glitch_then_press: got v=%b code=%0d expected v=1 code=0",
               key_valid, key_code); end
    keys_down[0] = 1'b0;
  endtask

  // Keys 1 and 13 share column 1 (sampled at 7, 23, 39): row 0 commits first.
  task automatic test_simultaneous();
    do_reset();
    keys_down[1]  = 1'b1;
    keys_down[13] = 1'b1;
    wait_cyc(25);
    vectors++; if (key_valid !== 1'b1 || key_code !== 4'd1) begin miscompares++;
      $display("FAIL simul_first: got v=%b code=%0d expected v=1 code=1", key_valid, key_code); end
    wait_cyc(41);
    vectors++; if (key_code !== 4'd1) begin miscompares++;
      $display("FAIL simul_head_kept: got %0d expected 1", key_code); end
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    vectors++; if (key_valid !== 1'b1 || key_code !== 4'd13) begin miscompares++;
      $display("FAIL simul_second: got v=%b code=%0d expected v=1 code=13",
               key_valid, key_code); end
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    vectors++; if (key_valid !== 1'b0) begin miscompares++;
      $display("FAIL simul_drained: got %b expected 0", key_valid); end
    keys_down = '0;
  endtask

  // Presses commit at 19 (0), 23 (5), 27 (10), 31 (15), 35 (4); the fifth is dropped.
  task automatic press_five();
    do_reset();
    key_ready = 1'b0;
    keys_down = 16'b1000_0100_0011_0001;  // keys 0, 4, 5, 10, 15
    wait_cyc(37);
    keys_down[8] = 1'b1;                  // commits at 67
  endtask

  task automatic test_overflow();
    press_five();
    vectors++; if (overflow !== 1'b1) begin miscompares++;
      $display("FAIL ovf_set: got %b expected 1", overflow); end
    vectors++; if (key_valid !== 1'b1 || key_code !== 4'd0) begin miscompares++;
      $display("FAIL ovf_head: got v=%b code=%0d expected v=1 code=0", key_valid, key_code); end
    wait_cyc(68);
    key_ready = 1'b1;
    tick();
    vectors++; if (key_code !== 4'd5) begin miscompares++;
      $display("FAIL full_pop_push_1: got %0d expected 5", key_code); end
    tick();
    vectors++; if (key_code !== 4'd10) begin miscompares++;
      $display("FAIL full_pop_push_2: got %0d expected 10", key_code); end
    tick();
    vectors++; if (key_code !== 4'd15) begin miscompares++;
      $display("FAIL full_pop_push_3: got %0d expected 15", key_code); end
    tick();
    vectors++; if (key_valid !== 1'b1 || key_code !== 4'd8) begin miscompares++;
      $display("FAIL full_pop_push_4: got v=%b code=%0d expected v=1 code=8",
               key_valid, key_code); end
    tick();
    vectors++; if (key_valid !== 1'b0 || key_code !== 4'd0) begin miscompares++;
      $display("FAIL ovf_empty: got v=%b code=%0d expected v=0 code=0", key_valid, key_code); end
    tick();
    vectors++; if (key_valid !== 1'b0 || overflow !== 1'b1) begin miscompares++;
      $display("FAIL ovf_sticky: got v=%b ovf=%b expected v=0 ovf=1", key_valid, overflow); end
    key_ready = 1'b0;
  endtask

  // Reset with a full FIFO, overflow set and key 8 one sample into its debounce.
  task automatic test_reset_mid();
    press_five();
    wait_cyc(55);
    vectors++; if (key_valid !== 1'b1 || overflow !== 1'b1) begin miscompares++;
      $display("FAIL mid_precond: got v=%b ovf=%b expected v=1 ovf=1", key_valid, overflow); end
    RST_BTN = 1'b1;
    tick();
    RST_BTN = 1'b0;
    keys_down = 16'h0100;
    vectors++; if (key_valid !== 1'b0 || overflow !== 1'b0 || col_drive !== 4'b1110) begin
      miscompares++;
      $display("FAIL mid_reset: got v=%b ovf=%b cd=%b expected v=0 ovf=0 cd=1110",
               key_valid, overflow, col_drive); end
    wait_cyc(5);
    vectors++; if (key_valid !== 1'b0 || any_held !== 1'b0) begin miscompares++;
      $display("FAIL mid_discard: got v=%b held=%b expected v=0 held=0", key_valid, any_held); end
    wait_cyc(20);
    vectors++; if (key_valid !== 1'b0) begin miscompares++;
      $display("FAIL mid_early: got %b expected 0", key_valid); end
    wait_cyc(21);
    vectors++; if (key_valid !== 1'b1 || key_code !== 4'd8 || any_held !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_fresh_press: got v=%b code=%0d held=%b expected v=1 code=8 held=1",
               key_valid, key_code, any_held); end
    wait_cyc(40);
    vectors++; if (overflow !== 1'b0) begin miscompares++;
      $display("FAIL mid_no_overflow: got %b expected 0", overflow); end
    keys_down = '0;
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_glitch();
    test_simultaneous();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
